// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two clients and physical memory.
// master is the arbiter's view; slave is the view of the clients and the memory.
interface mem_arbiter_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_write;
    logic [3:0]  imem_byte_enable;
    logic [31:0] imem_wdata;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_wdata;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    // The I-side write fields are carried for completeness; the arbiter never looks at them.
    modport master (
        input  imem_read, imem_address,
        output imem_resp, imem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        output dmem_resp, dmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        output imem_read, imem_address, imem_write, imem_byte_enable, imem_wdata,
        input  imem_resp, imem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
        input  dmem_resp, dmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: the D side has fixed priority over the I side.
// Define ARB_JOINT_RESP_EN to hold a D response back and deliver it together with a pending I response.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } state_e;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } pmem_cmd_t;

    state_e    state_q;
    pmem_cmd_t cmd_q;
    pmem_cmd_t d_cmd;
    pmem_cmd_t i_cmd;
    logic      d_req;
    logic      d_done;
    logic      i_done;
    logic      d_resp_direct;

    always_comb begin
        d_cmd             = '0;
        d_cmd.read        = bus.dmem_read & ~bus.dmem_write;
        d_cmd.write       = bus.dmem_write;
        d_cmd.address     = bus.dmem_address;
        d_cmd.byte_enable = bus.dmem_byte_enable;
        d_cmd.wdata       = bus.dmem_wdata;
        i_cmd             = '0;
        i_cmd.read        = 1'b1;
        i_cmd.address     = bus.imem_address;
        i_cmd.byte_enable = 4'hF;
    end

    assign d_req  = bus.dmem_read | bus.dmem_write;
    assign d_done = (state_q == SERVE_D) && bus.pmem_resp;
    assign i_done = (state_q == SERVE_I) && bus.pmem_resp;

`ifdef ARB_JOINT_RESP_EN
    logic        joint_q;
    logic [31:0] joint_rdata_q;
    // A D completion is held back whenever an I fetch is waiting behind it.
    assign d_resp_direct = d_done & ~bus.imem_read;
    assign bus.dmem_resp  = d_resp_direct | (i_done & joint_q);
    assign bus.dmem_rdata = d_resp_direct       ? bus.pmem_rdata :
                            (i_done & joint_q)  ? joint_rdata_q  : 32'h0;
`else
    assign d_resp_direct  = d_done;
    assign bus.dmem_resp  = d_resp_direct;
    assign bus.dmem_rdata = d_resp_direct ? bus.pmem_rdata : 32'h0;
`endif

    assign bus.imem_resp  = i_done;
    assign bus.imem_rdata = i_done ? bus.pmem_rdata : 32'h0;

    assign bus.pmem_read        = cmd_q.read;
    assign bus.pmem_write       = cmd_q.write;
    assign bus.pmem_address     = cmd_q.address;
    assign bus.pmem_byte_enable = cmd_q.byte_enable;
    assign bus.pmem_wdata       = cmd_q.wdata;

    // Returning to IDLE after each response gives the client one cycle to drop its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
`ifdef ARB_JOINT_RESP_EN
            joint_q       <= 1'b0;
            joint_rdata_q <= 32'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_req) begin
                        state_q <= SERVE_D;
                        cmd_q   <= d_cmd;
                    end else if (bus.imem_read) begin
                        state_q <= SERVE_I;
                        cmd_q   <= i_cmd;
                    end
                end
                SERVE_D: begin
                    if (bus.pmem_resp) begin
`ifdef ARB_JOINT_RESP_EN
                        if (bus.imem_read) begin
                            state_q       <= SERVE_I;
                            cmd_q         <= i_cmd;
                            joint_q       <= 1'b1;
                            joint_rdata_q <= bus.pmem_rdata;
                        end else begin
                            state_q <= IDLE;
                            cmd_q   <= '0;
                        end
`else
                        state_q <= IDLE;
                        cmd_q   <= '0;
`endif
                    end
                end
                SERVE_I: begin
                    if (bus.pmem_resp) begin
                        state_q <= IDLE;
                        cmd_q   <= '0;
`ifdef ARB_JOINT_RESP_EN
                        joint_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cmd_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model answers pmem requests and a
// scoreboard of expected client read data is checked as responses appear.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        cmd_t cmd;
        int   cycles;
    } served_t;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    served_t     served_q[$];
    int          mem_lat = 3;
    int          busy_cnt = 0;
    bit          stray = 1'b0;
    bit          prev_client_resp = 1'b0;
    cmd_t        first_cmd;
    int          i_resp_cycle = 0;
    int          d_resp_cycle = 0;
    int          req_cycle = 0;

    task automatic check(string tag, logic [69:0] obs, logic [69:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic cmd_t mk_cmd(logic r, logic w, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
        cmd_t c;
        c.read = r; c.write = w; c.address = a; c.be = be; c.wdata = wd;
        return c;
    endfunction

    function automatic cmd_t pmem_now();
        return mk_cmd(bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_byte_enable, bus.pmem_wdata);
    endfunction

    function automatic logic [31:0] mem_val(logic [31:0] a);
        case (a)
            32'h60:  return 32'h0000_0013;
            32'h80:  return 32'h00A0_0093;
            32'h200: return 32'hCAFE_F00D;
            32'h204: return 32'h00A0_0093;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // One clock cycle: memory model reacts, client outputs are scored, clients drop served requests.
    task automatic tick();
        cmd_t now;
        bit   active;
        now    = pmem_now();
        active = now.read | now.write;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 32'h0;
        if (prev_client_resp) check("idle_after_resp", {now.read, now.write}, 2'b00);
        if (active) begin
            busy_cnt++;
            if (busy_cnt == 1) first_cmd = now;
            else check("pmem_stable", now, first_cmd);
            if (busy_cnt >= mem_lat) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = now.read ? mem_val(now.address) : 32'h0;
                served_q.push_back('{cmd: now, cycles: busy_cnt});
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
            if (stray) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = 32'hDEAD_BEEF;
            end
        end
        #1;
        if (bus.imem_resp) begin
            check("i_resp_expected", exp_i_q.size() != 0, 1'b1);
            if (exp_i_q.size() != 0) check("imem_rdata", bus.imem_rdata, exp_i_q.pop_front());
            $display("txn cycle=%0d imem_resp rdata=%h", cycle, bus.imem_rdata);
            i_resp_cycle  = cycle;
            bus.imem_read = 1'b0;
        end else begin
            check("imem_rdata_zero", bus.imem_rdata, 32'h0);
        end
        if (bus.dmem_resp) begin
            check("d_resp_expected", exp_d_q.size() != 0, 1'b1);
            if (exp_d_q.size() != 0) check("dmem_rdata", bus.dmem_rdata, exp_d_q.pop_front());
            $display("txn cycle=%0d dmem_resp rdata=%h", cycle, bus.dmem_rdata);
            d_resp_cycle   = cycle;
            bus.dmem_read  = 1'b0;
            bus.dmem_write = 1'b0;
        end else begin
            check("dmem_rdata_zero", bus.dmem_rdata, 32'h0);
        end
        prev_client_resp = bus.imem_resp | bus.dmem_resp;
        @(negedge clk);
        cycle++;
    endtask

    task automatic run_until_done(string tag, int max_cycles);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            tick();
            done = (exp_i_q.size() == 0) && (exp_d_q.size() == 0) &&
                   !bus.imem_read && !bus.dmem_read && !bus.dmem_write;
        end
        check({tag, "_done"}, done, 1'b1);
        tick();
    endtask

    task automatic expect_served(string tag, cmd_t expc, int cycles_exp);
        served_t s;
        check({tag, "_logged"}, served_q.size() != 0, 1'b1);
        if (served_q.size() != 0) begin
            s = served_q.pop_front();
            check({tag, "_cmd"}, s.cmd, expc);
            if (cycles_exp > 0) check({tag, "_cycles"}, s.cycles, cycles_exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_read = 1'b0; bus.imem_address = 32'h0;
        bus.imem_write = 1'b1; bus.imem_byte_enable = 4'h5; bus.imem_wdata = 32'h1111_2222;
        bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; bus.dmem_address = 32'h0;
        bus.dmem_byte_enable = 4'h0; bus.dmem_wdata = 32'h0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);

        check("rst_pmem", pmem_now(), 70'h0);
        check("rst_resp", {bus.imem_resp, bus.dmem_resp}, 2'b00);
        check("rst_rdata", {bus.imem_rdata, bus.dmem_rdata}, 64'h0);
        rst = 1'b0;
        tick();

        // I-only fetch, memory answers on the third grant cycle
        mem_lat = 3;
        exp_i_q.push_back(32'h0000_0013);
        bus.imem_read = 1'b1; bus.imem_address = 32'h60;
        run_until_done("i_only", 20);
        expect_served("i_only", mk_cmd(1'b1, 1'b0, 32'h60, 4'hF, 32'h0), 3);

        // Minimum-latency D read; wdata is mirrored even on a read
        mem_lat = 1;
        exp_d_q.push_back(32'h5A5A_0500);
        bus.dmem_read = 1'b1; bus.dmem_address = 32'h500;
        bus.dmem_byte_enable = 4'hF; bus.dmem_wdata = 32'h1234;
        req_cycle = cycle;
        run_until_done("d_min", 10);
        check("d_min_latency", d_resp_cycle - req_cycle, 1);
        expect_served("d_min", mk_cmd(1'b1, 1'b0, 32'h500, 4'hF, 32'h1234), 1);

        // D write and I read together: D goes first
        mem_lat = 2;
        exp_d_q.push_back(32'h0);
        exp_i_q.push_back(32'h00A0_0093);
        bus.imem_read = 1'b1; bus.imem_address = 32'h80;
        bus.dmem_write = 1'b1; bus.dmem_address = 32'h100;
        bus.dmem_byte_enable = 4'h3; bus.dmem_wdata = 32'hBEEF;
        run_until_done("both_wr", 30);
        expect_served("both_wr_d", mk_cmd(1'b0, 1'b1, 32'h100, 4'h3, 32'hBEEF), 2);
        expect_served("both_wr_i", mk_cmd(1'b1, 1'b0, 32'h80, 4'hF, 32'h0), 2);
`ifdef ARB_JOINT_RESP_EN
        check("both_wr_joint", d_resp_cycle == i_resp_cycle, 1'b1);
`else
        check("both_wr_order", d_resp_cycle < i_resp_cycle, 1'b1);
`endif

        // D read and I read together
        exp_d_q.push_back(32'hCAFE_F00D);
        exp_i_q.push_back(32'h00A0_0093);
        bus.imem_read = 1'b1; bus.imem_address = 32'h204;
        bus.dmem_read = 1'b1; bus.dmem_address = 32'h200;
        bus.dmem_byte_enable = 4'hF; bus.dmem_wdata = 32'h0;
        run_until_done("both_rd", 30);
        expect_served("both_rd_d", mk_cmd(1'b1, 1'b0, 32'h200, 4'hF, 32'h0), 2);
        expect_served("both_rd_i", mk_cmd(1'b1, 1'b0, 32'h204, 4'hF, 32'h0), 2);
`ifdef ARB_JOINT_RESP_EN
        check("both_rd_joint", d_resp_cycle == i_resp_cycle, 1'b1);
`else
        check("both_rd_order", d_resp_cycle < i_resp_cycle, 1'b1);
`endif

        // Read and write asserted together count as a write
        exp_d_q.push_back(32'h0);
        bus.dmem_read = 1'b1; bus.dmem_write = 1'b1; bus.dmem_address = 32'h300;
        bus.dmem_byte_enable = 4'hC; bus.dmem_wdata = 32'h55AA;
        run_until_done("rw", 20);
        expect_served("rw", mk_cmd(1'b0, 1'b1, 32'h300, 4'hC, 32'h55AA), 2);

        // Stray pmem_resp while idle
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("stray_no_resp", {bus.imem_resp, bus.dmem_resp}, 2'b00);
        check("stray_stays_idle", pmem_now(), 70'h0);
        $display("txn cycle=%0d stray pmem_resp in idle", cycle);

        // Reset while D is being served
        mem_lat = 1000;
        bus.dmem_read = 1'b1; bus.dmem_address = 32'h400; bus.dmem_byte_enable = 4'hF;
        tick(); tick();
        check("pre_rst_read", bus.pmem_read, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pmem", pmem_now(), 70'h0);
        check("rst_async_resp", {bus.imem_resp, bus.dmem_resp}, 2'b00);
        bus.dmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        prev_client_resp = 1'b0;
        $display("txn cycle=%0d reset aborted D read", cycle);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("late_resp_ignored", {bus.imem_resp, bus.dmem_resp}, 2'b00);
        check("late_resp_idle", pmem_now(), 70'h0);

        mem_lat = 2;
        exp_i_q.push_back(32'h0000_0013);
        bus.imem_read = 1'b1; bus.imem_address = 32'h60;
        run_until_done("post_rst", 20);
        expect_served("post_rst", mk_cmd(1'b1, 1'b0, 32'h60, 4'hF, 32'h0), 2);
        check("served_drained", served_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
